data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory responder for the 8-bit datapath: the other end of the register file's bus interface. It accepts a read or write request whose address comes from the register file's address output (RY) and whose write data comes from its data output (RX). It services the request after a programmable number of wait states and returns read data that drives the register file's data-bus input for write-back. It holds the processor's data RAM and a small request/acknowledge FSM.

## Interface
- WAIT_STATES, default 2 — idle cycles inserted before each access; legal 0..15.
- MEM_WORDS, default 256 — implemented words; legal 1..256; addresses ≥ MEM_WORDS are out of range.

- i_Clk  in  1  clock; all state changes on rising edge.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Req  in  1  request strobe; sampled only in IDLE.
- i_We  in  1  1 = write, 0 = read; sampled with i_Req.
- i_Addr  in  8  word address (register file RY output).
- i_Wdata  in  8  write data (register file RX output).
- o_Busy  out  1  high while a request is in progress (WAIT, ACCESS, DONE).
- o_Ack  out  1  one-cycle completion pulse.
- o_Err  out  1  out-of-range flag; valid only with o_Ack.
- o_Rdata  out  8  last read result; held until the next read completes.

## Operation
- States: IDLE, WAIT, ACCESS, DONE. All outputs are registered or decoded from state.
- IDLE:
  - o_Busy=0.
  - On i_Req=1, latch i_We, i_Addr and i_Wdata into internal registers.
  - Load the wait counter with WAIT_STATES.
  - Next state is WAIT if WAIT_STATES>0, otherwise ACCESS.
- WAIT:
  - Decrement the counter each cycle.
  - Leave for ACCESS on the edge where the counter reaches 0; the FSM spends exactly WAIT_STATES cycles in WAIT.
- ACCESS: one cycle. On its closing edge:
  - Write, in range: mem[addr] ← latched wdata; o_Rdata unchanged.
  - Read, in range: o_Rdata ← mem[addr].
  - Out of range: no memory write. A read loads o_Rdata ← 8'h00. o_Err ← 1.
  - o_Ack ← 1. Next state is DONE.
- DONE: one cycle with o_Ack=1 (o_Err as set). Then to IDLE with o_Ack=0 and o_Err=0.
- i_Req while o_Busy=1 is ignored, not queued. The latched inputs isolate the transaction from input changes mid-request.
- Memory contents are not reset: undefined at power-up, preserved across i_Rst.
- Reset mid-transaction aborts it:
  - no memory write occurs and no o_Ack is produced;
  - state returns to IDLE.
- Reset values: state=IDLE, o_Busy=0, o_Ack=0, o_Err=0, o_Rdata=8'h00, wait counter=0.

## Timing
- Request sampled at edge E0 (IDLE, i_Req=1); o_Busy goes high after E0.
- ACCESS occupies the cycle after edge E0+WAIT_STATES.
- Memory update and o_Rdata load happen at edge E0+WAIT_STATES+1.
- o_Ack is high for exactly one cycle, between edges E0+W+1 and E0+W+2 (W = WAIT_STATES).
- At edge E0+W+2 the FSM returns to IDLE and o_Busy drops.
- Earliest next request is sampled at edge E0+W+3. Throughput is one transaction per W+3 cycles.
- o_Rdata is valid while o_Ack is high and stays stable afterwards.
- Read-after-write to the same address returns the new data (the write completes before the read is accepted).
- i_Req held continuously high starts back-to-back transactions, each sampled in IDLE.

## Test plan
- Reset, WAIT_STATES=2:
  - Stimulus: write 8'hA5 to addr 8'h10, then read addr 8'h10.
  - Required: o_Ack 3 cycles after each request edge; o_Rdata=8'hA5 during the read's o_Ack; o_Err=0.
- WAIT_STATES=0:
  - Stimulus: hold i_Req=1 with alternating write 8'h3C @8'h01 and read @8'h01.
  - Required: a new transaction every 3 cycles; o_Ack pulses 1 cycle each; read returns 8'h3C.
- Busy ignore:
  - Stimulus: during a read of 8'h20, pulse i_Req with write 8'hFF @8'h20 while o_Busy=1.
  - Required: no second o_Ack; a later read of 8'h20 returns its prior value.
- MEM_WORDS=16:
  - Stimulus: write 8'h77 @8'h1F, then read @8'h1F.
  - Required: both o_Ack with o_Err=1; read o_Rdata=8'h00; mem[8'h0F] unchanged.
- Reset mid-transaction:
  - Stimulus: assert i_Rst during WAIT of a write 8'h55 @8'h05 (prior content 8'h11).
  - Required: o_Busy/o_Ack/o_Err/o_Rdata=0 immediately; a later read @8'h05 returns 8'h11.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the 8-bit datapath: serves one read or write
// request at a time after WAIT_STATES idle cycles, with a one-cycle ack.
// Ports:
//   i_Clk, i_Rst          clock, async active-high reset
//   i_Req, i_We           request strobe (sampled in IDLE), 1 = write
//   i_Addr, i_Wdata       word address and write data
//   o_Busy                request in progress (WAIT, ACCESS, DONE)
//   o_Ack, o_Err          one-cycle completion pulse, out-of-range flag
//   o_Rdata               last read result, held until the next read
module data_mem_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int MEM_WORDS   = 256
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Req,
    input  logic       i_We,
    input  logic [7:0] i_Addr,
    input  logic [7:0] i_Wdata,
    output logic       o_Busy,
    output logic       o_Ack,
    output logic       o_Err,
    output logic [7:0] o_Rdata
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [8:0] LIMIT = 9'(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            we_q;
    logic [7:0]      addr_q;
    logic [7:0]      wdata_q;
    logic            in_range;
    logic [AW-1:0]   idx;
    logic [7:0]      mem [MEM_WORDS];

    assign in_range = {1'b0, addr_q} < LIMIT;
    assign idx      = addr_q[AW-1:0];
    assign o_Busy   = (state != S_IDLE);

    // Memory has no reset so its contents survive i_Rst; an async reset
    // forces IDLE, so an aborted request can never reach this write.
    always_ff @(posedge i_Clk) begin
        if (state == S_ACCESS && we_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            o_Ack   <= 1'b0;
            o_Err   <= 1'b0;
            o_Rdata <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_Req) begin
                        we_q    <= i_We;
                        addr_q  <= i_Addr;
                        wdata_q <= i_Wdata;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    // Counter hits zero on the edge that leaves WAIT,
                    // giving exactly WAIT_STATES cycles here.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    o_Ack <= 1'b1;
                    if (!in_range) begin
                        o_Err <= 1'b1;
                        if (!we_q) begin
                            o_Rdata <= 8'h00;
                        end
                    end else if (!we_q) begin
                        o_Rdata <= mem[idx];
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    o_Ack <= 1'b0;
                    o_Err <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: two instances (W=2/256 words, W=0/16 words)
// driven per lane; expected acks queued at issue and checked by a monitor.
module tb_data_mem_ctrl;

    logic       clk;
    logic       rst;
    logic       req   [2];
    logic       we    [2];
    logic [7:0] addr  [2];
    logic [7:0] wdata [2];
    logic       busy  [2];
    logic       ack   [2];
    logic       err   [2];
    logic [7:0] rdata [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] rd;
        bit         rd_known;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] mem_m    [2][256];
    bit         known    [2][256];
    logic [7:0] last_rd  [2];
    bit         lr_known [2];

    data_mem_ctrl #(.WAIT_STATES(2), .MEM_WORDS(256)) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req[0]), .i_We(we[0]),
        .i_Addr(addr[0]), .i_Wdata(wdata[0]), .o_Busy(busy[0]),
        .o_Ack(ack[0]), .o_Err(err[0]), .o_Rdata(rdata[0])
    );

    data_mem_ctrl #(.WAIT_STATES(0), .MEM_WORDS(16)) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req[1]), .i_We(we[1]),
        .i_Addr(addr[1]), .i_Wdata(wdata[1]), .o_Busy(busy[1]),
        .o_Ack(ack[1]), .o_Err(err[1]), .o_Rdata(rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int lane_w(int id);
        return (id == 0) ? 2 : 0;
    endfunction

    function automatic int lane_words(int id);
        return (id == 0) ? 256 : 16;
    endfunction

    function automatic void chk(string nm, int id, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lane%0d actual=%0h required=%0h t=%0t",
                     nm, id, act, exp, $time);
        end
    endfunction

    task automatic mon(int id);
        exp_t e;
        if (ack[id] === 1'b1) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack lane%0d actual=1 required=0 t=%0t",
                         id, $time);
            end else begin
                e = (id == 0) ? q0.pop_front() : q1.pop_front();
                chk("ack_cycle", id, cyc, e.cyc);
                chk("err", id, int'(err[id]), int'(e.err));
                if (e.rd_known) chk("rdata", id, int'(rdata[id]), int'(e.rd));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Called at a negedge; returns at the negedge where the lane is idle.
    task automatic wait_idle(int id);
        int n = 0;
        while (busy[id] !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout lane%0d actual=busy required=idle", id);
        end
    endtask

    task automatic issue(int id, bit w, logic [7:0] a, logic [7:0] d,
                         bit hold, output int c0);
        exp_t e;
        wait_idle(id);
        req[id]   = 1'b1;
        we[id]    = w;
        addr[id]  = a;
        wdata[id] = d;
        @(posedge clk);
        #1;
        c0       = cyc;
        e.cyc    = c0 + lane_w(id) + 1;
        e.err    = (int'(a) >= lane_words(id));
        if (e.err) begin
            if (!w) begin
                last_rd[id]  = 8'h00;
                lr_known[id] = 1'b1;
            end
        end else if (w) begin
            mem_m[id][a] = d;
            known[id][a] = 1'b1;
        end else begin
            last_rd[id]  = mem_m[id][a];
            lr_known[id] = known[id][a];
        end
        e.rd       = last_rd[id];
        e.rd_known = lr_known[id];
        if (id == 0) q0.push_back(e);
        else q1.push_back(e);
        @(negedge clk);
        if (!hold) req[id] = 1'b0;
    endtask

    task automatic rand_lane(int id, int n);
        int c;
        for (int i = 0; i < n; i++) begin
            issue(id, 1'($urandom), 8'($urandom_range(0, 31)),
                  8'($urandom), 1'b0, c);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int prev;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 8'h00; wdata[i] = 8'h00;
            last_rd[i] = 8'h00; lr_known[i] = 1'b1;
            for (int j = 0; j < 256; j++) known[i][j] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_busy", i, int'(busy[i]), 0);
            chk("rst_ack", i, int'(ack[i]), 0);
            chk("rst_err", i, int'(err[i]), 0);
            chk("rst_rdata", i, int'(rdata[i]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Write then read back, W=2
        issue(0, 1'b1, 8'h10, 8'hA5, 1'b0, c);
        issue(0, 1'b0, 8'h10, 8'h00, 1'b0, c);

        // Back-to-back with i_Req held, W=0
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            issue(1, (i % 2) == 0, 8'h01, 8'h3C, i != 5, c);
            if (i > 0) chk("b2b_gap", 1, c - prev, 3);
            prev = c;
        end

        // Out of range on the 16-word instance
        issue(1, 1'b1, 8'h0F, 8'h99, 1'b0, c);
        issue(1, 1'b1, 8'h1F, 8'h77, 1'b0, c);
        issue(1, 1'b0, 8'h1F, 8'h00, 1'b0, c);
        issue(1, 1'b0, 8'h0F, 8'h00, 1'b0, c);

        // Request while busy is ignored
        issue(0, 1'b1, 8'h20, 8'h42, 1'b0, c);
        issue(0, 1'b0, 8'h20, 8'h00, 1'b0, c);
        chk("busy_during_pulse", 0, int'(busy[0]), 1);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h20; wdata[0] = 8'hFF;
        @(negedge clk);
        req[0] = 1'b0;
        issue(0, 1'b0, 8'h20, 8'h00, 1'b0, c);

        // Reset during WAIT of a write aborts it
        issue(0, 1'b1, 8'h05, 8'h11, 1'b0, c);
        issue(0, 1'b0, 8'h05, 8'h00, 1'b0, c);
        wait_idle(0);
        wait_idle(1);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h05; wdata[0] = 8'h55;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 0, int'(busy[0]), 0);
        chk("midrst_ack", 0, int'(ack[0]), 0);
        chk("midrst_err", 0, int'(err[0]), 0);
        chk("midrst_rdata", 0, int'(rdata[0]), 0);
        for (int i = 0; i < 2; i++) begin
            last_rd[i] = 8'h00;
            lr_known[i] = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(0, 1'b0, 8'h05, 8'h00, 1'b0, c);

        // Randomized traffic on both lanes
        fork
            rand_lane(0, 40);
            rand_lane(1, 60);
        join

        repeat (10) @(negedge clk);
        chk("pending_acks", 0, q0.size(), 0);
        chk("pending_acks", 1, q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
